// File: rtl/bfm_adder_if.sv
// ---------------------------------------------------------------------------
// bfm_adder_if
//
// Purpose:
//   Groups the operand/result signals of bfm_adder into one bundle.
//   The block has no handshake. Every clock edge samples A_s/B_s, and
//   res_o is a pure registered output.
//
// Signals:
//   A_s          WIDTH  operand A (master -> slave)
//   B_s          WIDTH  operand B (master -> slave)
//   res_o        WIDTH  registered sum (slave -> master)
//   sample_cnt_o 32     non-reset edges seen   (only with BFM_ADDER_STATS_EN)
//   carry_cnt_o  16     samples with carry-out (only with BFM_ADDER_STATS_EN)
//
// Modports:
//   master  drives the operands and observes the results (wrapper/bench side)
//   slave   the adder itself
//
// Optional feature macro: BFM_ADDER_STATS_EN
// ---------------------------------------------------------------------------
interface bfm_adder_if #(
    parameter int WIDTH = 8
);

    logic [WIDTH-1:0] A_s;
    logic [WIDTH-1:0] B_s;
    logic [WIDTH-1:0] res_o;

`ifdef BFM_ADDER_STATS_EN
    logic [31:0]      sample_cnt_o;
    logic [15:0]      carry_cnt_o;

    modport master (
        output A_s,
        output B_s,
        input  res_o,
        input  sample_cnt_o,
        input  carry_cnt_o
    );

    modport slave (
        input  A_s,
        input  B_s,
        output res_o,
        output sample_cnt_o,
        output carry_cnt_o
    );
`else
    modport master (
        output A_s,
        output B_s,
        input  res_o
    );

    modport slave (
        input  A_s,
        input  B_s,
        output res_o
    );
`endif

endinterface

// File: rtl/bfm_adder.sv
// ---------------------------------------------------------------------------
// bfm_adder
//
// Purpose:
//   Pipelined WIDTH-bit adder. Each rising edge of clk_i samples the two
//   operands and forms their sum. The sum either wraps modulo 2^WIDTH or
//   clamps to all-ones on carry-out. The result reaches res_o LATENCY edges
//   after the operands were presented. There is no handshake and no stall.
//
// Ports:
//   clk_i    in   1      clock; all logic on the rising edge
//   reset_i  in   1      synchronous, active-high reset; flushes the pipeline
//   bus      slave       bfm_adder_if: A_s, B_s in; res_o out
//                        (+ sample_cnt_o, carry_cnt_o with the stats option)
//
// Parameters:
//   WIDTH     2..32  operand and result width
//   LATENCY   1..8   edges from operand sample to res_o update
//   SATURATE  0/1    0 = wrap, 1 = clamp at 2^WIDTH-1 on carry-out
//
// Optional feature macro: BFM_ADDER_STATS_EN
//   When defined, the block adds a saturating 32-bit count of non-reset edges
//   and a saturating 16-bit count of samples whose raw sum carried out.
//   Both counters update on the sampling edge and are not delayed by
//   LATENCY.
// ---------------------------------------------------------------------------
module bfm_adder #(
    parameter int WIDTH    = 8,
    parameter int LATENCY  = 1,
    parameter int SATURATE = 0
) (
    input  logic        clk_i,
    input  logic        reset_i,
    bfm_adder_if.slave  bus
);

    // -----------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -----------------------------------------------------------------------
    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("bfm_adder: WIDTH=%0d outside legal range 2..32", WIDTH);
        end
        if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
            $error("bfm_adder: LATENCY=%0d outside legal range 1..8", LATENCY);
        end
        if (SATURATE != 0 && SATURATE != 1) begin : g_bad_saturate
            $error("bfm_adder: SATURATE=%0d must be 0 or 1", SATURATE);
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Sum path
    // -----------------------------------------------------------------------
    // The sum is formed one bit wider so that the carry-out is explicit. The
    // carry drives both the saturation clamp and the optional carry counter.
    logic [WIDTH:0]   sum_w;
    logic             carry_w;
    logic [WIDTH-1:0] result_d;

    assign sum_w   = {1'b0, bus.A_s} + {1'b0, bus.B_s};
    assign carry_w = sum_w[WIDTH];

    generate
        if (SATURATE != 0) begin : g_sat
            assign result_d = carry_w ? {WIDTH{1'b1}} : sum_w[WIDTH-1:0];
        end else begin : g_wrap
            assign result_d = sum_w[WIDTH-1:0];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Result pipeline
    // -----------------------------------------------------------------------
    // Stage 0 captures the new result. Each later stage copies its
    // predecessor. res_o is the last stage, so a sample taken on edge n
    // appears after edge n+LATENCY-1. A reset edge clears every stage, so no
    // result that was in flight survives the reset. Operands present on the
    // reset edge are discarded.
    logic [WIDTH-1:0] pipe_q [LATENCY];
    logic [WIDTH-1:0] pipe_d [LATENCY];

    always_comb begin
        pipe_d[0] = result_d;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign bus.res_o = pipe_q[LATENCY-1];

`ifdef BFM_ADDER_STATS_EN
    // -----------------------------------------------------------------------
    // Statistics counters
    // -----------------------------------------------------------------------
    // Both counters stick at all-ones instead of rolling over. A reading of
    // all-ones therefore means "at least this many", never a small number
    // after a wrap. The carry count uses the raw carry-out. It counts the
    // same way in wrap mode and in saturate mode.
    logic [31:0] sample_cnt_q;
    logic [31:0] sample_cnt_d;
    logic [15:0] carry_cnt_q;
    logic [15:0] carry_cnt_d;

    always_comb begin
        sample_cnt_d = sample_cnt_q;
        carry_cnt_d  = carry_cnt_q;
        if (sample_cnt_q != 32'hFFFF_FFFF) begin
            sample_cnt_d = sample_cnt_q + 32'd1;
        end
        if (carry_w && (carry_cnt_q != 16'hFFFF)) begin
            carry_cnt_d = carry_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sample_cnt_q <= '0;
            carry_cnt_q  <= '0;
        end else begin
            sample_cnt_q <= sample_cnt_d;
            carry_cnt_q  <= carry_cnt_d;
        end
    end

    assign bus.sample_cnt_o = sample_cnt_q;
    assign bus.carry_cnt_o  = carry_cnt_q;
`endif

endmodule

// File: tb/tb_bfm_adder.sv
// ---------------------------------------------------------------------------
// tb_bfm_adder
//
// Four adder instances share one operand stream and one reset:
//   u_l1_wrap  LATENCY=1 SATURATE=0
//   u_l1_sat   LATENCY=1 SATURATE=1
//   u_l3_sat   LATENCY=3 SATURATE=1
//   u_l4_wrap  LATENCY=4 SATURATE=0
// Inputs change 1 time unit after each rising edge. Outputs are read at the
// same point, so each read shows the state left by the edge just taken.
// ---------------------------------------------------------------------------
module tb_bfm_adder;

    localparam int W = 8;

    // -----------------------------------------------------------------------
    // Clock / reset
    // -----------------------------------------------------------------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_r = 1'b1;
    logic [W-1:0] a_r   = '0;
    logic [W-1:0] b_r   = '0;

    // -----------------------------------------------------------------------
    // DUTs
    // -----------------------------------------------------------------------
    bfm_adder_if #(.WIDTH(W)) bus_l1w ();
    bfm_adder_if #(.WIDTH(W)) bus_l1s ();
    bfm_adder_if #(.WIDTH(W)) bus_l3s ();
    bfm_adder_if #(.WIDTH(W)) bus_l4w ();

    assign bus_l1w.A_s = a_r;  assign bus_l1w.B_s = b_r;
    assign bus_l1s.A_s = a_r;  assign bus_l1s.B_s = b_r;
    assign bus_l3s.A_s = a_r;  assign bus_l3s.B_s = b_r;
    assign bus_l4w.A_s = a_r;  assign bus_l4w.B_s = b_r;

    bfm_adder #(.WIDTH(W), .LATENCY(1), .SATURATE(0)) u_l1_wrap (
        .clk_i(clk), .reset_i(rst_r), .bus(bus_l1w)
    );
    bfm_adder #(.WIDTH(W), .LATENCY(1), .SATURATE(1)) u_l1_sat (
        .clk_i(clk), .reset_i(rst_r), .bus(bus_l1s)
    );
    bfm_adder #(.WIDTH(W), .LATENCY(3), .SATURATE(1)) u_l3_sat (
        .clk_i(clk), .reset_i(rst_r), .bus(bus_l3s)
    );
    bfm_adder #(.WIDTH(W), .LATENCY(4), .SATURATE(0)) u_l4_wrap (
        .clk_i(clk), .reset_i(rst_r), .bus(bus_l4w)
    );

    // -----------------------------------------------------------------------
    // Checker
    // -----------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // -----------------------------------------------------------------------
    // Driver tasks
    // -----------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rst, input logic [W-1:0] a, input logic [W-1:0] b);
        rst_r = rst;
        a_r   = a;
        b_r   = b;
    endtask

    task automatic check_all(input string tag, input logic [W-1:0] e_l1w, input logic [W-1:0] e_l1s,
                             input logic [W-1:0] e_l3s, input logic [W-1:0] e_l4w);
        check({tag, "_l1w"}, 32'(bus_l1w.res_o), 32'(e_l1w));
        check({tag, "_l1s"}, 32'(bus_l1s.res_o), 32'(e_l1s));
        check({tag, "_l3s"}, 32'(bus_l3s.res_o), 32'(e_l3s));
        check({tag, "_l4w"}, 32'(bus_l4w.res_o), 32'(e_l4w));
    endtask

`ifdef BFM_ADDER_STATS_EN
    task automatic check_stats(input string tag, input logic [31:0] e_samp, input logic [15:0] e_carry);
        check({tag, "_samp_l1w"},  bus_l1w.sample_cnt_o, e_samp);
        check({tag, "_samp_l4w"},  bus_l4w.sample_cnt_o, e_samp);
        check({tag, "_carry_l1w"}, 32'(bus_l1w.carry_cnt_o), 32'(e_carry));
        check({tag, "_carry_l3s"}, 32'(bus_l3s.carry_cnt_o), 32'(e_carry));
    endtask
`endif

    // Hand-computed tables for the latency sequence 1+1, 2+2, 3+3, 0+0...
    logic [W-1:0] lat_a   [7] = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0};
    logic [W-1:0] lat_l1  [7] = '{8'd2, 8'd4, 8'd6, 8'd0, 8'd0, 8'd0, 8'd0};
    logic [W-1:0] lat_l3  [7] = '{8'd0, 8'd0, 8'd2, 8'd4, 8'd6, 8'd0, 8'd0};
    logic [W-1:0] lat_l4  [7] = '{8'd0, 8'd0, 8'd0, 8'd2, 8'd4, 8'd6, 8'd0};

    // Mid-stream reset: 10+10, 20+20, 30+30, reset edge (50+50 dropped), then 7+8 held
    logic         mr_rst  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [W-1:0] mr_a    [8] = '{8'd10, 8'd20, 8'd30, 8'd50, 8'd7, 8'd7, 8'd7, 8'd7};
    logic [W-1:0] mr_b    [8] = '{8'd10, 8'd20, 8'd30, 8'd50, 8'd8, 8'd8, 8'd8, 8'd8};
    logic [W-1:0] mr_l1   [8] = '{8'd20, 8'd40, 8'd60, 8'd0, 8'd15, 8'd15, 8'd15, 8'd15};
    logic [W-1:0] mr_l3   [8] = '{8'd0,  8'd0,  8'd20, 8'd0, 8'd0,  8'd0,  8'd15, 8'd15};
    logic [W-1:0] mr_l4   [8] = '{8'd0,  8'd0,  8'd0,  8'd0, 8'd0,  8'd0,  8'd0,  8'd15};

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin
        // Reset held for three edges with non-zero operands present
        drive(1'b1, 8'd5, 8'd7);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all($sformatf("reset%0d", i), 8'd0, 8'd0, 8'd0, 8'd0);
`ifdef BFM_ADDER_STATS_EN
            check_stats($sformatf("reset%0d", i), 32'd0, 16'd0);
`endif
        end

        // Basic add: 1+2 held for 2000 cycles
        drive(1'b0, 8'd1, 8'd2);
        for (int i = 0; i < 2000; i++) begin
            tick();
            check_all($sformatf("basic%0d", i), 8'd3, 8'd3,
                      (i >= 2) ? 8'd3 : 8'd0, (i >= 3) ? 8'd3 : 8'd0);
        end
`ifdef BFM_ADDER_STATS_EN
        check_stats("basic_end", 32'd2000, 16'd0);
`endif

        // Wrap vs saturate: 200+100 = 300 -> 44 wrapped, 255 clamped
        drive(1'b0, 8'd200, 8'd100);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("wrap%0d", i), 32'(bus_l1w.res_o), 32'd44);
            check($sformatf("sat%0d", i),  32'(bus_l1s.res_o), 32'd255);
`ifdef BFM_ADDER_STATS_EN
            check_stats($sformatf("carry%0d", i), 32'd2001 + 32'(i), 16'(i + 1));
`endif
        end
        check("wrap_l4", 32'(bus_l4w.res_o), 32'd44);
        check("sat_l3",  32'(bus_l3s.res_o), 32'd255);

        // Clean start for the latency sequence
        drive(1'b1, 8'd0, 8'd0);
        tick();
        check_all("pre_lat_reset", 8'd0, 8'd0, 8'd0, 8'd0);

        for (int i = 0; i < 7; i++) begin
            drive(1'b0, lat_a[i], lat_a[i]);
            tick();
            check_all($sformatf("lat%0d", i + 1), lat_l1[i], lat_l1[i], lat_l3[i], lat_l4[i]);
        end
`ifdef BFM_ADDER_STATS_EN
        check_stats("lat_end", 32'd7, 16'd0);
`endif

        // Mid-stream reset with three results in flight
        for (int i = 0; i < 8; i++) begin
            drive(mr_rst[i], mr_a[i], mr_b[i]);
            tick();
            check_all($sformatf("midrst%0d", i + 1), mr_l1[i], mr_l1[i], mr_l3[i], mr_l4[i]);
        end
`ifdef BFM_ADDER_STATS_EN
        check_stats("midrst_end", 32'd4, 16'd0);
`endif

        // Extremes: 255+255 -> 254 wrapped / 255 clamped
        drive(1'b0, 8'd255, 8'd255);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("max_wrap%0d", i), 32'(bus_l1w.res_o), 32'd254);
            check($sformatf("max_sat%0d", i),  32'(bus_l1s.res_o), 32'd255);
        end
        check("max_l3", 32'(bus_l3s.res_o), 32'd255);
        check("max_l4", 32'(bus_l4w.res_o), 32'd254);

        // 0+0 -> 0 once the pipelines drain
        drive(1'b0, 8'd0, 8'd0);
        tick();
        check("zero_l1w", 32'(bus_l1w.res_o), 32'd0);
        check("zero_l1s", 32'(bus_l1s.res_o), 32'd0);
        for (int i = 0; i < 3; i++) tick();
        check_all("zero_end", 8'd0, 8'd0, 8'd0, 8'd0);
`ifdef BFM_ADDER_STATS_EN
        check_stats("final", 32'd12, 16'd4);
`endif

        // Report
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
